// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Shares one downstream bridge bus between NUM_REQ requesters. Each requester
//   has a one-entry command buffer; a round-robin scheduler issues buffered
//   commands one at a time and routes read data (or a timeout substitute) back
//   to the requester that issued the read.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_addr/req_wr_data         per-requester command address / write data
//   req_rd/req_wr                per-requester single-cycle command pulses
//   req_rd_data/_valid           per-requester read response
//   bridge_out_addr/_wr_data     downstream command address / write data
//   bridge_out_rd/_wr            downstream single-cycle command pulses
//   bridge_out_rd_data/_valid    downstream read response
//   busy                         scheduler not idle
//   overflow                     sticky per-requester dropped-command flag
//   timeout_count                saturating count of read timeouts
module bridge_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    parameter logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0][31:0]  req_addr,
    input  logic [NUM_REQ-1:0][31:0]  req_wr_data,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    output logic [NUM_REQ-1:0][31:0]  req_rd_data,
    output logic [NUM_REQ-1:0]        req_rd_data_valid,
    output logic [31:0]               bridge_out_addr,
    output logic [31:0]               bridge_out_wr_data,
    output logic                      bridge_out_rd,
    output logic                      bridge_out_wr,
    input  logic [31:0]               bridge_out_rd_data,
    input  logic                      bridge_out_rd_data_valid,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        overflow,
    output logic [15:0]               timeout_count
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GRANT_RESET = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    state_t state, next_state;

    logic [NUM_REQ-1:0]       pend_v;
    logic [NUM_REQ-1:0]       pend_rd;
    logic [NUM_REQ-1:0][31:0] pend_addr;
    logic [NUM_REQ-1:0][31:0] pend_wdata;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant_idx;
    logic          grant_found;
    logic          grant;
    logic          cur_rd;
    logic [CW-1:0] wait_cnt;
    logic          rsp_v;
    logic          rsp_timeout;

    // Round-robin pick: first pending index after last_grant, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            logic [GW-1:0] idx;
            idx = GW'((32'(last_grant) + k) % NUM_REQ);
            if (!grant_found && pend_v[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign grant = (state == IDLE) && grant_found;

    // Next-state and response decode.
    always_comb begin
        next_state  = state;
        rsp_v       = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) next_state = ISSUE;
            end
            ISSUE: begin
                if (!cur_rd) begin
                    next_state = IDLE;
                end else if (bridge_out_rd_data_valid) begin
                    rsp_v      = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bridge_out_rd_data_valid) begin
                    rsp_v      = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    rsp_v       = 1'b1;
                    rsp_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // Command buffers: a new pulse in the grant cycle reloads the entry
    // rather than being dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v     <= '0;
            pend_rd    <= '0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            overflow   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_rd[i] || req_wr[i]) begin
                    if (pend_v[i] && !(grant && (grant_idx == GW'(i)))) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        pend_v[i]     <= 1'b1;
                        pend_rd[i]    <= req_rd[i];
                        pend_addr[i]  <= req_addr[i];
                        pend_wdata[i] <= req_wr_data[i];
                    end
                end else if (grant && (grant_idx == GW'(i))) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    // Downstream issue, read timeout and response routing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bridge_out_addr    <= '0;
            bridge_out_wr_data <= '0;
            bridge_out_rd      <= 1'b0;
            bridge_out_wr      <= 1'b0;
            cur_rd             <= 1'b0;
            last_grant         <= GRANT_RESET;
            wait_cnt           <= '0;
            req_rd_data        <= '0;
            req_rd_data_valid  <= '0;
            timeout_count      <= '0;
        end else begin
            bridge_out_rd     <= 1'b0;
            bridge_out_wr     <= 1'b0;
            req_rd_data_valid <= '0;

            if (grant) begin
                bridge_out_addr    <= pend_addr[grant_idx];
                bridge_out_wr_data <= pend_wdata[grant_idx];
                bridge_out_rd      <= pend_rd[grant_idx];
                bridge_out_wr      <= !pend_rd[grant_idx];
                cur_rd             <= pend_rd[grant_idx];
                last_grant         <= grant_idx;
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT_RD) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (rsp_v) begin
                req_rd_data[last_grant]       <= rsp_timeout ? RD_TIMEOUT_DATA : bridge_out_rd_data;
                req_rd_data_valid[last_grant] <= 1'b1;
                if (rsp_timeout && (timeout_count != 16'hFFFF)) begin
                    timeout_count <= timeout_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter
//   Directed bench for bridge_arbiter (NUM_REQ = 2, TIMEOUT_CYCLES = 4).
//   A cycle table covers the write/read/round-robin flow; hand sequences
//   cover overflow, read timeout, same-cycle valid and reset mid-read.
module tb_bridge_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wr_data;
    logic [1:0]       req_rd;
    logic [1:0]       req_wr;
    logic [1:0][31:0] req_rd_data;
    logic [1:0]       req_rd_data_valid;
    logic [31:0]      bridge_out_addr;
    logic [31:0]      bridge_out_wr_data;
    logic             bridge_out_rd;
    logic             bridge_out_wr;
    logic [31:0]      bridge_out_rd_data;
    logic             bridge_out_rd_data_valid;
    logic             busy;
    logic [1:0]       overflow;
    logic [15:0]      timeout_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    bridge_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (4),
        .RD_TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .req_addr                (req_addr),
        .req_wr_data             (req_wr_data),
        .req_rd                  (req_rd),
        .req_wr                  (req_wr),
        .req_rd_data             (req_rd_data),
        .req_rd_data_valid       (req_rd_data_valid),
        .bridge_out_addr         (bridge_out_addr),
        .bridge_out_wr_data      (bridge_out_wr_data),
        .bridge_out_rd           (bridge_out_rd),
        .bridge_out_wr           (bridge_out_wr),
        .bridge_out_rd_data      (bridge_out_rd_data),
        .bridge_out_rd_data_valid(bridge_out_rd_data_valid),
        .busy                    (busy),
        .overflow                (overflow),
        .timeout_count           (timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        bv;
        logic [31:0] bd;
        logic        brd;
        logic        bwr;
        logic [31:0] baddr;
        logic [31:0] bwd;
        logic [1:0]  rv;
        logic [31:0] rdat0;
        logic        busy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_brd"},   32'(bridge_out_rd), 32'd0);
        chk({tag, "_bwr"},   32'(bridge_out_wr), 32'd0);
        chk({tag, "_baddr"}, bridge_out_addr, 32'd0);
        chk({tag, "_bwd"},   bridge_out_wr_data, 32'd0);
        chk({tag, "_rdat0"}, req_rd_data[0], 32'd0);
        chk({tag, "_rdat1"}, req_rd_data[1], 32'd0);
        chk({tag, "_rv"},    32'(req_rd_data_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_tcnt"},  32'(timeout_count), 32'd0);
    endtask

    initial begin
        // Table: outputs expected in cycle k, inputs driven during cycle k.
        //           rd     wr     bv   bd             brd  bwr  baddr        bwd          rv     rdat0          busy
        tbl[0]  = '{2'b00, 2'b11, 1'b0, 32'h0,         1'b0,1'b0,32'h0,       32'h0,       2'b00, 32'h0,         1'b0};
        tbl[1]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h0,       32'h0,       2'b00, 32'h0,         1'b0};
        tbl[2]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b1,32'h100,     32'hA0,      2'b00, 32'h0,         1'b1};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h0,         1'b0};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b1,32'h200,     32'hB0,      2'b00, 32'h0,         1'b1};
        tbl[5]  = '{2'b01, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h200,     32'hB0,      2'b00, 32'h0,         1'b0};
        tbl[6]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h200,     32'hB0,      2'b00, 32'h0,         1'b0};
        tbl[7]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b1,1'b0,32'h100,     32'hA0,      2'b00, 32'h0,         1'b1};
        tbl[8]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h0,         1'b1};
        tbl[9]  = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h0,         1'b1};
        tbl[10] = '{2'b00, 2'b00, 1'b1, 32'h1234_5678, 1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h0,         1'b1};
        tbl[11] = '{2'b00, 2'b11, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b01, 32'h1234_5678, 1'b0};
        tbl[12] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h1234_5678, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b1,32'h200,     32'hB0,      2'b00, 32'h1234_5678, 1'b1};
        tbl[14] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h200,     32'hB0,      2'b00, 32'h1234_5678, 1'b0};
        tbl[15] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b1,32'h100,     32'hA0,      2'b00, 32'h1234_5678, 1'b1};
        tbl[16] = '{2'b00, 2'b00, 1'b1, 32'h55,        1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h1234_5678, 1'b0};
        tbl[17] = '{2'b00, 2'b00, 1'b0, 32'h0,         1'b0,1'b0,32'h100,     32'hA0,      2'b00, 32'h1234_5678, 1'b0};

        reset_n                  = 1'b0;
        req_addr[0]              = 32'h0000_0100;
        req_addr[1]              = 32'h0000_0200;
        req_wr_data[0]           = 32'h0000_00A0;
        req_wr_data[1]           = 32'h0000_00B0;
        req_rd                   = '0;
        req_wr                   = '0;
        bridge_out_rd_data       = '0;
        bridge_out_rd_data_valid = 1'b0;

        tick();
        tick();
        chk_reset_values("reset");
        reset_n = 1'b1;

        // Simultaneous writes after reset, single read, round-robin repeat.
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("t%0d_brd", k),   32'(bridge_out_rd), 32'(tbl[k].brd));
            chk($sformatf("t%0d_bwr", k),   32'(bridge_out_wr), 32'(tbl[k].bwr));
            chk($sformatf("t%0d_baddr", k), bridge_out_addr, tbl[k].baddr);
            chk($sformatf("t%0d_bwd", k),   bridge_out_wr_data, tbl[k].bwd);
            chk($sformatf("t%0d_rv", k),    32'(req_rd_data_valid), 32'(tbl[k].rv));
            chk($sformatf("t%0d_rdat0", k), req_rd_data[0], tbl[k].rdat0);
            chk($sformatf("t%0d_rdat1", k), req_rd_data[1], 32'h0);
            chk($sformatf("t%0d_busy", k),  32'(busy), 32'(tbl[k].busy));
            req_rd                   = tbl[k].rd;
            req_wr                   = tbl[k].wr;
            bridge_out_rd_data_valid = tbl[k].bv;
            bridge_out_rd_data       = tbl[k].bd;
        end
        chk("tbl_ovf",  32'(overflow), 32'd0);
        chk("tbl_tcnt", 32'(timeout_count), 32'd0);

        // Overflow during WAIT_RD, then read timeout.
        tick();
        req_rd[0] = 1'b1;
        tick();
        req_rd[0] = 1'b0;
        tick();
        chk("ovf_issue_rd", 32'(bridge_out_rd), 32'd1);
        tick();
        req_wr[1] = 1'b1;
        tick();
        tick();
        req_wr[1] = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'b10);
        chk("ovf_busy", 32'(busy), 32'd1);
        tick();
        chk("to_no_early_rv", 32'(req_rd_data_valid), 32'd0);
        tick();
        chk("to_rv",    32'(req_rd_data_valid), 32'b01);
        chk("to_rdat0", req_rd_data[0], 32'hDEAD_BEEF);
        chk("to_tcnt",  32'(timeout_count), 32'd1);
        tick();
        chk("ovf_wr1",    32'(bridge_out_wr), 32'd1);
        chk("ovf_addr1",  bridge_out_addr, 32'h200);
        chk("to_rv_once", 32'(req_rd_data_valid), 32'd0);
        bridge_out_rd_data       = 32'h7777_7777;
        bridge_out_rd_data_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            bridge_out_rd_data_valid = 1'b0;
            chk($sformatf("ovf_no_2nd_wr%0d", k), 32'(bridge_out_wr), 32'd0);
            chk($sformatf("late_rv%0d", k),       32'(req_rd_data_valid), 32'd0);
        end
        chk("late_rdat0", req_rd_data[0], 32'hDEAD_BEEF);

        // Read from requester 1 answered in its ISSUE cycle.
        req_rd[1] = 1'b1;
        tick();
        req_rd[1] = 1'b0;
        tick();
        chk("sc_issue_rd",   32'(bridge_out_rd), 32'd1);
        chk("sc_issue_addr", bridge_out_addr, 32'h200);
        bridge_out_rd_data       = 32'hCAFE_F00D;
        bridge_out_rd_data_valid = 1'b1;
        tick();
        bridge_out_rd_data_valid = 1'b0;
        chk("sc_rv",    32'(req_rd_data_valid), 32'b10);
        chk("sc_rdat1", req_rd_data[1], 32'hCAFE_F00D);
        chk("sc_busy",  32'(busy), 32'd0);
        chk("sc_rdat0", req_rd_data[0], 32'hDEAD_BEEF);
        chk("sc_tcnt",  32'(timeout_count), 32'd1);

        // Reset asserted during WAIT_RD.
        req_rd[0] = 1'b1;
        tick();
        req_rd[0] = 1'b0;
        tick();
        chk("rst_issue_rd", 32'(bridge_out_rd), 32'd1);
        tick();
        chk("rst_wait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        tick();
        reset_n = 1'b1;
        tick();
        req_rd[0] = 1'b1;
        tick();
        req_rd[0] = 1'b0;
        tick();
        chk("post_rd",   32'(bridge_out_rd), 32'd1);
        chk("post_addr", bridge_out_addr, 32'h100);
        tick();
        bridge_out_rd_data       = 32'h0BAD_F00D;
        bridge_out_rd_data_valid = 1'b1;
        tick();
        bridge_out_rd_data_valid = 1'b0;
        chk("post_rv",    32'(req_rd_data_valid), 32'b01);
        chk("post_rdat0", req_rd_data[0], 32'h0BAD_F00D);
        chk("post_busy",  32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Shares one downstream bridge bus between NUM_REQ independent bridge requesters, for example the APF host bridge and a core-side configuration engine, ahead of a bridge splitter. Each requester issues single-cycle rd/wr pulses and has one command buffered. A round-robin scheduler serialises the buffered commands onto the downstream bus, one at a time. Read data, or a timeout substitute, is routed back to the requester that issued the read.

## Interface
- NUM_REQ, 2: number of requester ports, 2..8.
- TIMEOUT_CYCLES, 256: cycles a read may wait for rd_data_valid before being failed; must be ≥1.
- RD_TIMEOUT_DATA, 32'hDEAD_BEEF: data returned on a read timeout.
- clk  in  1  sole clock; every bus_if clk is driven from this clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  bus_if  [NUM_REQ]  requester side: addr, wr_data, rd, wr in; rd_data, rd_data_valid out. 32-bit data and address.
- bridge_out  bus_if  1  downstream side: addr, wr_data, rd, wr out; rd_data, rd_data_valid in. 32-bit data and address.
- busy  out  1  high whenever the state is not IDLE.
- overflow  out  NUM_REQ  sticky per requester; set when a command is dropped.
- timeout_count  out  16  saturating count of read timeouts.

## Operation
- Per-requester buffer, one entry: pend_v, pend_rd, pend_addr, pend_wdata.
  - A req[i].rd or req[i].wr pulse loads the buffer on the next edge. If both rd and wr are high, rd wins.
  - A pulse that arrives while pend_v is set and the buffer is not being granted that cycle is dropped, and overflow[i] is set.
  - A pulse in the same cycle the buffer is granted is accepted: load wins over clear.
- Scheduler states are IDLE, ISSUE and WAIT_RD.
- IDLE:
  - If any pend_v is set, pick the first set index searching from last_grant+1 upward, with wrap.
  - Latch that buffer's addr, wdata and kind into the bridge_out registers, clear its pend_v, set last_grant, and go to ISSUE.
- ISSUE:
  - bridge_out.wr or bridge_out.rd is high for exactly this cycle.
  - A write goes to IDLE.
  - A read goes to WAIT_RD, unless bridge_out.rd_data_valid is already high in this cycle. In that case it completes as described under WAIT_RD.
- WAIT_RD:
  - The timeout counter counts up from 0.
  - On bridge_out.rd_data_valid: register req[last_grant].rd_data from bridge_out.rd_data, pulse req[last_grant].rd_data_valid for 1 cycle, and go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no valid: return RD_TIMEOUT_DATA with a 1-cycle valid, increment timeout_count (saturating at 16'hFFFF), and go to IDLE.
- rd_data_valid from downstream in IDLE, or in ISSUE for a write, is ignored.
- Only the granted requester ever sees rd_data_valid. The rd_data of other requesters holds its last value.
- bridge_out.addr and bridge_out.wr_data hold their value from the grant until the next grant.
- Writes produce no response to the requester.

## Timing
- Reset values:
  - all pend_v = 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - bridge_out.rd, wr, addr and wr_data = 0.
  - all req rd_data = 0 and rd_data_valid = 0.
  - busy = 0; overflow = 0; timeout_count = 0.
- Reset asserted mid-transaction aborts it with no response, and all buffered commands are lost.
- Request pulse at cycle N: pend_v is set at N+1, and with an idle arbiter the downstream pulse is at N+2.
- Downstream rd_data_valid at cycle M: requester rd_data_valid at M+1, state is IDLE at M+1, and the next downstream pulse is at M+2 at the earliest.
- Back-to-back writes from different requesters reach the downstream bus every 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single read: req[0].rd with addr 32'h0000_0100 at cycle 0; downstream returns 32'h1234_5678 with valid at cycle 5.
  - Required: bridge_out.rd at cycle 2 with addr 32'h100; req[0].rd_data = 32'h1234_5678 with valid at cycle 6.
  - Required: req[1].rd_data_valid never rises.
- Simultaneous writes: req[0].wr and req[1].wr in the same cycle after reset.
  - Required: requester 0 is issued first and requester 1 two cycles later, each with its own addr and wr_data.
  - Repeat the test: requester 1 now wins, confirming round-robin.
- Overflow: req[1].wr twice on consecutive cycles while a read from req[0] is in WAIT_RD.
  - Required: the second command is dropped, overflow = 2'b10, and only the first write is issued.
- Read timeout: TIMEOUT_CYCLES = 4, downstream never answers.
  - Required: requester gets 32'hDEAD_BEEF with a 1-cycle valid and timeout_count = 1.
  - A late downstream valid in IDLE causes no requester valid.
- Same-cycle valid: downstream asserts rd_data_valid in the ISSUE cycle.
  - Required: response returned the next cycle, with no pass through WAIT_RD.
- Reset mid-read: reset_n pulled low during WAIT_RD.
  - Required: all outputs are at their reset values immediately.
  - Required: after release, the first new request is served normally.
